// File: rtl/ins_fetch_unit_pkg.sv
// ins_fetch_unit_pkg: fetch-stage state encoding and constants shared with IF/ID and hazard logic
package ins_fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} fetch_state_t;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
endpackage

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: PC owner issuing instruction-memory reads and feeding IF/ID with valid/stall
module ins_fetch_unit
    import ins_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_read,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_busy
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  target;
    logic         complete;
    logic         consume;

    assign pc_next    = pc + 32'd4;
    assign target     = branch_target & WORD_ALIGN_MASK;
    assign complete   = (state == FETCH) && mem_read && !mem_busywait && (!instr_valid || !stall);
    assign consume    = instr_valid && !stall;
    assign fetch_busy = mem_read & mem_busywait;

    // Fetch FSM: redirect beats completion/consumption; a read in flight on redirect is drained in DISCARD
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_read    <= 1'b0;
            mem_address <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else if (branch_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    mem_read    <= 1'b1;
                    mem_address <= target;
                end
                FETCH: begin
                    if (mem_busywait)
                        state <= DISCARD;
                    else
                        mem_address <= target;
                end
                default: state <= DISCARD;
            endcase
        end else begin
            if (complete) begin
                instr       <= mem_readdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (consume) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    mem_read    <= 1'b1;
                    mem_address <= pc;
                end
                FETCH: begin
                    if (complete) begin
                        pc          <= pc_next;
                        mem_address <= pc_next;
                    end
                end
                DISCARD: begin
                    if (!mem_busywait) begin
                        state       <= FETCH;
                        mem_address <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
